envelope_length: RTL and testbench
==================================

# envelope_length

Per-channel envelope generator and length counter for the APU audio path, sitting directly downstream of the frame sequencer. It consumes the single-cycle 240 Hz (quarter-frame) and 120 Hz (half-frame) enables. It produces a 4-bit volume, either decaying or constant, that is gated to zero when the channel's length counter expires. One instance serves each pulse or noise channel.

## Interface
Parameters:
- none. The length table and all widths are fixed.

Ports:
- clk  in  1  system clock, about 1.79 MHz
- reset  in  1  synchronous, active-high
- enable_240hz  in  1  quarter-frame tick, one-cycle pulse
- enable_120hz  in  1  half-frame tick, one-cycle pulse; always coincides with an enable_240hz pulse
- reg_wr  in  1  control register write strobe
- reg_data  in  8  control data: [5] halt/loop, [4] constant, [3:0] volume/period V; bits [7:6] ignored
- len_wr  in  1  length load strobe; also restarts the envelope
- len_idx  in  5  length table index
- channel_en  in  1  channel enable; 0 forces the length counter to 0
- volume  out  4  registered output volume
- active  out  1  registered flag, high when length != 0

## Operation
Registers:
- halt, cnst, V[3:0]
- start
- divider[3:0], decay[3:0]
- length[7:0]

Reset sets every register and both outputs to 0.

Control write: when reg_wr=1, {halt, cnst, V} is loaded from reg_data[5:0] at the next edge.

Envelope, evaluated on an edge where enable_240hz=1:
- If start=1: clear start, decay=15, divider=V.
- Else if divider==0: divider=V, then:
  - if decay!=0, decay=decay-1;
  - else if halt=1, decay=15 (loop);
  - else decay stays 0.
- Else: divider=divider-1.

Length counter:
- If channel_en=0: length=0 at every edge, and len_wr is ignored for length.
- Else if len_wr=1: length=LUT[len_idx].
- Else if enable_120hz=1, length!=0 and halt=0: length=length-1.
- Length never wraps below 0.

LUT[0..31]: 10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14, 12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30.

Start flag: set by len_wr regardless of channel_en.

Outputs:
- volume <= (length==0) ? 0 : (cnst ? V : decay)
- active <= (length!=0)

Simultaneous events:
- reg_wr with either tick: the tick uses the pre-write halt, cnst and V. The new values apply from the next cycle.
- len_wr with enable_240hz: the tick acts on the old start value, and start is 1 after the edge (set dominates the clear).
- len_wr with enable_120hz: the load wins; no decrement occurs that cycle.
- channel_en=0 with len_wr: length=0.
- Reset asserted mid-operation: all state returns to 0 at that edge, regardless of strobes or ticks.

## Timing
- All state updates on the rising clk edge on which the strobe or tick is sampled high.
- volume and active are computed from registered state. They lag a state change by exactly one cycle.
- Latency, len_wr to active=1: 2 edges (edge 1 loads length, edge 2 updates active).
- Envelope period with constant V and no restart: V+1 quarter-frame ticks per decay step.
- Decay from a restart to 0: 1 tick (restart) + 15×(V+1) ticks.
- No handshakes exist; strobes are single-cycle and are never back-pressured.
- Consecutive write strobes on adjacent cycles are each honoured in order.

## Test plan
- **Reset:** hold reset 2 cycles while strobes toggle -> volume=0, active=0. With no writes afterwards, outputs stay 0 across 10 ticks.
- **Constant volume:** reg_wr 0x19 (cnst=1, V=9), then len_wr idx=1 (254) with channel_en=1 -> active=1 and volume=9 two edges later. Halt=0, so active falls after 254 enable_120hz pulses, and volume=0 the cycle after.
- **Decay:** reg_wr 0x02 (V=2), len_wr idx=3 (length 2 is too short for this test, so use idx=1) -> first tick gives volume=15, then volume drops by 1 every 3 ticks, reaching 0 after 46 ticks and holding at 0.
- **Loop and halt:** reg_wr 0x20 (halt=1, V=0), len_wr idx=0 -> decay steps 15,14,…,0,15 on consecutive ticks. length stays 10 through 50 half-frame ticks.
- **Channel disable:** load idx=5 (4), then drop channel_en -> active=0 and volume=0 two edges later. A len_wr while channel_en=0 leaves length=0.
- **Collisions:**
  - len_wr in the same cycle as enable_120hz -> length equals the LUT value, not LUT-1.
  - reg_wr in the same cycle as enable_240hz -> that tick's divider reload uses the old V.

Source files
------------

// File: rtl/envelope_length.sv
// envelope_length
//   Per-channel envelope generator and length counter for the APU audio path.
//   Driven by the frame sequencer's quarter-frame (240 Hz) and half-frame
//   (120 Hz) single-cycle enables. Produces a 4-bit volume (decaying envelope
//   or constant) that is forced to zero while the length counter is zero.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high; clears all state and outputs
//   enable_240hz quarter-frame tick (envelope clock)
//   enable_120hz half-frame tick (length clock), coincides with enable_240hz
//   reg_wr       control write strobe; reg_data[5]=halt/loop, [4]=constant,
//                [3:0]=volume/period V
//   reg_data     control data
//   len_wr       length load strobe from the table index; restarts envelope
//   len_idx      length table index
//   channel_en   0 holds the length counter at zero
//   volume       registered output volume
//   active       registered flag, high while length is non-zero
module envelope_length (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable_240hz,
    input  logic       enable_120hz,
    input  logic       reg_wr,
    input  logic [7:0] reg_data,
    input  logic       len_wr,
    input  logic [4:0] len_idx,
    input  logic       channel_en,
    output logic [3:0] volume,
    output logic       active
);

    logic       halt;
    logic       cnst;
    logic [3:0] v;
    logic       start;
    logic [3:0] divider;
    logic [3:0] decay;
    logic [7:0] length;
    logic [7:0] lut_value;

    // Length load table.
    always_comb begin
        lut_value = '0;
        case (len_idx)
            5'd0:  lut_value = 8'd10;
            5'd1:  lut_value = 8'd254;
            5'd2:  lut_value = 8'd20;
            5'd3:  lut_value = 8'd2;
            5'd4:  lut_value = 8'd40;
            5'd5:  lut_value = 8'd4;
            5'd6:  lut_value = 8'd80;
            5'd7:  lut_value = 8'd6;
            5'd8:  lut_value = 8'd160;
            5'd9:  lut_value = 8'd8;
            5'd10: lut_value = 8'd60;
            5'd11: lut_value = 8'd10;
            5'd12: lut_value = 8'd14;
            5'd13: lut_value = 8'd12;
            5'd14: lut_value = 8'd26;
            5'd15: lut_value = 8'd14;
            5'd16: lut_value = 8'd12;
            5'd17: lut_value = 8'd16;
            5'd18: lut_value = 8'd24;
            5'd19: lut_value = 8'd18;
            5'd20: lut_value = 8'd48;
            5'd21: lut_value = 8'd20;
            5'd22: lut_value = 8'd96;
            5'd23: lut_value = 8'd22;
            5'd24: lut_value = 8'd192;
            5'd25: lut_value = 8'd24;
            5'd26: lut_value = 8'd72;
            5'd27: lut_value = 8'd26;
            5'd28: lut_value = 8'd16;
            5'd29: lut_value = 8'd28;
            5'd30: lut_value = 8'd32;
            5'd31: lut_value = 8'd30;
            default: lut_value = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            halt    <= 1'b0;
            cnst    <= 1'b0;
            v       <= '0;
            start   <= 1'b0;
            divider <= '0;
            decay   <= '0;
            length  <= '0;
            volume  <= '0;
            active  <= 1'b0;
        end else begin
            // Ticks in this cycle read the pre-write control values because
            // all reads below see the registers before this edge.
            if (reg_wr) begin
                halt <= reg_data[5];
                cnst <= reg_data[4];
                v    <= reg_data[3:0];
            end

            if (enable_240hz) begin
                if (start) begin
                    start   <= 1'b0;
                    decay   <= 4'd15;
                    divider <= v;
                end else if (divider == 4'd0) begin
                    divider <= v;
                    if (decay != 4'd0)
                        decay <= decay - 4'd1;
                    else if (halt)
                        decay <= 4'd15;
                end else begin
                    divider <= divider - 4'd1;
                end
            end

            // Placed after the tick so a coincident load leaves start set.
            if (len_wr)
                start <= 1'b1;

            if (!channel_en)
                length <= '0;
            else if (len_wr)
                length <= lut_value;
            else if (enable_120hz && (length != 8'd0) && !halt)
                length <= length - 8'd1;

            volume <= (length == 8'd0) ? 4'd0 : (cnst ? v : decay);
            active <= (length != 8'd0);
        end
    end

endmodule

// File: tb/tb_envelope_length.sv
module tb_envelope_length;

    logic       clk;
    logic       reset;
    logic       enable_240hz;
    logic       enable_120hz;
    logic       reg_wr;
    logic [7:0] reg_data;
    logic       len_wr;
    logic [4:0] len_idx;
    logic       channel_en;
    logic [3:0] volume;
    logic       active;

    int total = 0;
    int bad   = 0;

    int lut [32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                     12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};

    // Reference model state (plain integers)
    int m_halt, m_cnst, m_v, m_start, m_div, m_dec, m_len, m_vol, m_act;

    envelope_length dut (
        .clk          (clk),
        .reset        (reset),
        .enable_240hz (enable_240hz),
        .enable_120hz (enable_120hz),
        .reg_wr       (reg_wr),
        .reg_data     (reg_data),
        .len_wr       (len_wr),
        .len_idx      (len_idx),
        .channel_en   (channel_en),
        .volume       (volume),
        .active       (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, advance model, compare outputs after edge.
    task automatic cyc(input logic rs, input logic rw, input logic [7:0] rd,
                       input logic lw, input logic [4:0] li,
                       input logic q, input logic h);
        int n_halt, n_cnst, n_v, n_start, n_div, n_dec, n_len, n_vol, n_act;
        reset = rs; reg_wr = rw; reg_data = rd; len_wr = lw; len_idx = li;
        enable_240hz = q | h; enable_120hz = h;

        n_halt = m_halt; n_cnst = m_cnst; n_v = m_v; n_start = m_start;
        n_div = m_div; n_dec = m_dec; n_len = m_len;
        n_vol = (m_len == 0) ? 0 : (m_cnst != 0 ? m_v : m_dec);
        n_act = (m_len != 0) ? 1 : 0;
        if (rw) begin
            n_halt = rd[5]; n_cnst = rd[4]; n_v = rd[3:0];
        end
        if (q | h) begin
            if (m_start != 0) begin
                n_start = 0; n_dec = 15; n_div = m_v;
            end else if (m_div == 0) begin
                n_div = m_v;
                if (m_dec > 0) n_dec = m_dec - 1;
                else if (m_halt != 0) n_dec = 15;
            end else begin
                n_div = m_div - 1;
            end
        end
        if (lw) n_start = 1;
        if (!channel_en) n_len = 0;
        else if (lw) n_len = lut[li];
        else if (h && m_len > 0 && m_halt == 0) n_len = m_len - 1;
        if (rs) begin
            n_halt = 0; n_cnst = 0; n_v = 0; n_start = 0; n_div = 0;
            n_dec = 0; n_len = 0; n_vol = 0; n_act = 0;
        end

        @(posedge clk);
        #1;
        m_halt = n_halt; m_cnst = n_cnst; m_v = n_v; m_start = n_start;
        m_div = n_div; m_dec = n_dec; m_len = n_len; m_vol = n_vol; m_act = n_act;
        chk("model_volume", {4'd0, volume}, m_vol[7:0]);
        chk("model_active", {7'd0, active}, m_act[7:0]);
    endtask

    task automatic idle();        cyc(0, 0, 8'h00, 0, 5'd0, 0, 0); endtask
    task automatic qt();          cyc(0, 0, 8'h00, 0, 5'd0, 1, 0); endtask
    task automatic hf();          cyc(0, 0, 8'h00, 0, 5'd0, 1, 1); endtask
    task automatic wr(input logic [7:0] d); cyc(0, 1, d, 0, 5'd0, 0, 0); endtask
    task automatic ld(input logic [4:0] i); cyc(0, 0, 8'h00, 1, i, 0, 0); endtask

    initial begin
        m_halt = 0; m_cnst = 0; m_v = 0; m_start = 0; m_div = 0;
        m_dec = 0; m_len = 0; m_vol = 0; m_act = 0;
        channel_en = 1'b1;

        // Reset held two cycles while strobes toggle
        cyc(1, 1, 8'h3F, 1, 5'd1, 1, 1);
        cyc(1, 0, 8'h00, 0, 5'd0, 0, 0);
        chk("reset_volume", {4'd0, volume}, 8'd0);
        chk("reset_active", {7'd0, active}, 8'd0);
        repeat (10) hf();
        chk("post_reset_volume", {4'd0, volume}, 8'd0);
        chk("post_reset_active", {7'd0, active}, 8'd0);

        // Constant volume, length 254 counted down by half-frames
        wr(8'h19);
        ld(5'd1);
        idle();
        chk("const_active", {7'd0, active}, 8'd1);
        chk("const_volume", {4'd0, volume}, 8'd9);
        repeat (253) hf();
        idle();
        chk("len_253_active", {7'd0, active}, 8'd1);
        hf();
        idle();
        chk("len_expired_active", {7'd0, active}, 8'd0);
        chk("len_expired_volume", {4'd0, volume}, 8'd0);

        // Decay with V=2
        wr(8'h02);
        ld(5'd1);
        qt();
        qt();
        chk("decay_first", {4'd0, volume}, 8'd15);
        repeat (44) qt();
        idle();
        chk("decay_zero", {4'd0, volume}, 8'd0);
        repeat (6) qt();
        chk("decay_hold", {4'd0, volume}, 8'd0);
        chk("decay_active", {7'd0, active}, 8'd1);

        // Loop and halt, V=0
        wr(8'h20);
        ld(5'd0);
        for (int i = 1; i <= 50; i++) begin
            hf();
            if (i == 17) chk("loop_bottom", {4'd0, volume}, 8'd0);
            if (i == 18) chk("loop_wrap", {4'd0, volume}, 8'd15);
        end
        idle();
        chk("halt_active", {7'd0, active}, 8'd1);

        // Channel disable
        wr(8'h17);
        ld(5'd5);
        idle();
        chk("chan_on_active", {7'd0, active}, 8'd1);
        chk("chan_on_volume", {4'd0, volume}, 8'd7);
        channel_en = 1'b0;
        idle();
        idle();
        chk("chan_off_active", {7'd0, active}, 8'd0);
        chk("chan_off_volume", {4'd0, volume}, 8'd0);
        ld(5'd1);
        idle();
        idle();
        chk("chan_off_load", {7'd0, active}, 8'd0);
        channel_en = 1'b1;

        // len_wr coincident with half-frame: load wins
        wr(8'h1F);
        cyc(0, 0, 8'h00, 1, 5'd3, 1, 1);
        hf();
        idle();
        chk("coll_len_one_left", {7'd0, active}, 8'd1);
        hf();
        idle();
        chk("coll_len_expired", {7'd0, active}, 8'd0);

        // reg_wr coincident with quarter-frame: reload uses old V
        wr(8'h05);
        ld(5'd1);
        qt();
        repeat (5) qt();
        cyc(0, 1, 8'h01, 0, 5'd0, 1, 0);
        qt();
        qt();
        idle();
        chk("coll_reg_old_v", {4'd0, volume}, 8'd14);

        // Randomized phase
        for (int i = 0; i < 600; i++) begin
            logic q, h;
            channel_en = ($urandom_range(7) != 0);
            h = ($urandom_range(7) == 0);
            q = h | ($urandom_range(3) == 0);
            cyc(($urandom_range(63) == 0), ($urandom_range(7) == 0), 8'($urandom),
                ($urandom_range(9) == 0), 5'($urandom), q, h);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
